uart_rx_param: RTL and testbench

Parametrised UART receiver: the next generation of the team's fixed-format receive FSM. It adds configurable oversampling, data width, parity and stop bits, start-bit glitch rejection, and a valid/ready output with per-frame error flags. It sits between the async `rx` pin and the byte-stream consumer (command parser / RX FIFO).

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Types shared by the parametrised UART receiver and the future transmitter:
// FSM state encoding and the frame-format parameter set.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    typedef struct packed {
        int clk_div;
        int data_bits;
        int parity_en;
        int parity_odd;
        int stop_bits;
    } uart_cfg_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; resets to 1 so a
// reset never looks like a falling edge.
module uart_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled bit timer, start-glitch rejection,
// optional parity, 1/2 stop bits, valid/ready output with per-frame flags.
//
// state     | meaning
// IDLE      | line idle, waiting for rx_s low
// START     | half a bit into the start bit; re-check low or reject glitch
// DATA      | sampling DATA_BITS data bits, LSB first
// PARITY    | sampling the parity bit
// STOP      | sampling STOP_BITS stop bits
// WAIT_HIGH | line held low after the frame (break); wait for it to return high
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam uart_cfg_t CFG = '{clk_div: CLK_DIV, data_bits: DATA_BITS,
                                  parity_en: PARITY_EN, parity_odd: PARITY_ODD,
                                  stop_bits: STOP_BITS};
    localparam int            CW        = $clog2(CFG.clk_div);
    localparam logic [CW-1:0] HALF_M1   = CW'(CFG.clk_div / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CFG.clk_div - 1);
    localparam logic [3:0]    DATA_LAST = 4'(CFG.data_bits - 1);
    localparam logic [3:0]    STOP_LAST = 4'(CFG.stop_bits - 1);
    localparam logic          PAR_EN    = (CFG.parity_en != 0);
    localparam logic          PAR_ODD   = (CFG.parity_odd != 0);

    logic rx_s;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   done_q, done_d;
    logic [DATA_BITS-1:0]   m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d;
    logic                   parity_err_q, parity_err_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q, overrun_d;
    logic                   tick;

    uart_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign tick = (cnt_q == BIT_LAST);

    always_comb begin
        state_d      = state_q;
        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        bcnt_d       = bcnt_q;
        sh_d         = sh_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        done_d       = 1'b0;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bcnt_d  = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    sh_d   = {rx_s, sh_q[DATA_BITS-1:1]};
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == DATA_LAST) begin
                        bcnt_d  = '0;
                        state_d = PAR_EN ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    perr_d  = ((^{sh_q, rx_s}) != PAR_ODD);
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (!rx_s) ferr_d = 1'b1;
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == STOP_LAST) begin
                        done_d  = 1'b1;
                        state_d = rx_s ? IDLE : WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase

        // A held, unaccepted word wins over a newly completed frame.
        if (done_q && (!m_valid_q || m_ready)) begin
            m_data_d     = sh_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q;
            m_valid_d    = 1'b1;
        end else if (done_q) begin
            overrun_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bcnt_q       <= '0;
            sh_q         <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            done_q       <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bcnt_q       <= bcnt_d;
            sh_q         <= sh_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            done_q       <= done_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers with different frame
// formats, directed scenarios plus randomized traffic against a frame model.
module tb_uart_rx_param;

    localparam int DIV  [3] = '{16, 6, 10};
    localparam int DB   [3] = '{8, 7, 8};
    localparam int PEN  [3] = '{0, 1, 1};
    localparam int PODD [3] = '{0, 0, 1};
    localparam int NS   [3] = '{1, 2, 1};

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        longint     due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rx      [3];
    logic m_ready [3];
    logic mv [3];
    logic pe [3];
    logic fe [3];
    logic ov [3];
    logic bz [3];
    logic pv [3];
    logic [7:0] md0;
    logic [6:0] md1;
    logic [7:0] md2;
    logic [7:0] md_all [3];

    exp_t   exp_q [3][$];
    int     exp_ovr [3] = '{0, 0, 0};
    int     got_ovr [3] = '{0, 0, 0};
    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign md_all[0] = md0;
    assign md_all[1] = {1'b0, md1};
    assign md_all[2] = md2;

    uart_rx_param dut0 (
        .clk(clk), .rst(rst), .rx(rx[0]), .m_data(md0), .m_valid(mv[0]),
        .m_ready(m_ready[0]), .parity_err(pe[0]), .frame_err(fe[0]),
        .overrun(ov[0]), .busy(bz[0])
    );

    uart_rx_param #(.CLK_DIV(6), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .rx(rx[1]), .m_data(md1), .m_valid(mv[1]),
        .m_ready(m_ready[1]), .parity_err(pe[1]), .frame_err(fe[1]),
        .overrun(ov[1]), .busy(bz[1])
    );

    uart_rx_param #(.CLK_DIV(10), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .rx(rx[2]), .m_data(md2), .m_valid(mv[2]),
        .m_ready(m_ready[2]), .parity_err(pe[2]), .frame_err(fe[2]),
        .overrun(ov[2]), .busy(bz[2])
    );

    task automatic chk(input string name, input int ch, input longint act, input longint expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h (t=%0t)", name, ch, act, expv, $time);
        end
    endtask

    // Parity bit value that makes the frame's parity correct for the channel.
    function automatic logic par_of(input int ch, input logic [7:0] d);
        int m;
        logic [7:0] dm;
        m  = (1 << DB[ch]) - 1;
        dm = d & m[7:0];
        return 1'(($countones(dm) + PODD[ch]) % 2);
    endfunction

    task automatic drive_bit(input int ch, input logic b);
        rx[ch] = b;
        repeat (DIV[ch]) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one frame; the expected word and flags come from the frame contents.
    // With raise=0 a frame ending in a low stop bit leaves the line low.
    task automatic send_frame(input int ch, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2, input bit raise);
        exp_t e;
        int m;
        logic [7:0] dm;
        logic last;
        m  = (1 << DB[ch]) - 1;
        dm = d & m[7:0];
        e.data = dm;
        e.perr = (PEN[ch] != 0) && ((($countones(dm) + int'(pbit)) % 2) != PODD[ch]);
        e.ferr = !s1 || (NS[ch] == 2 && !s2);
        e.due  = cyc + 4 + DIV[ch] / 2 + (DB[ch] + PEN[ch] + NS[ch]) * DIV[ch];
        if (!m_ready[ch] && exp_q[ch].size() != 0) exp_ovr[ch]++;
        else exp_q[ch].push_back(e);
        drive_bit(ch, 1'b0);
        for (int i = 0; i < DB[ch]; i++) drive_bit(ch, dm[i]);
        if (PEN[ch] != 0) drive_bit(ch, pbit);
        drive_bit(ch, s1);
        if (NS[ch] == 2) drive_bit(ch, s2);
        last = (NS[ch] == 2) ? s2 : s1;
        if (!last && raise) begin
            rx[ch] = 1'b1;
            idle(DIV[ch]);
        end
    endtask

    task automatic rand_ch(input int ch, input int n);
        logic [7:0] d;
        logic pb;
        logic s1;
        logic s2;
        for (int i = 0; i < n; i++) begin
            d  = 8'($urandom);
            pb = par_of(ch, d) ^ ($urandom_range(0, 3) == 0);
            s1 = ($urandom_range(0, 7) != 0);
            s2 = ($urandom_range(0, 7) != 0);
            send_frame(ch, d, pb, s1, s2, 1'b1);
            idle($urandom_range(0, DIV[ch]));
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        for (int ch = 0; ch < 3; ch++) chk("drain_pending", ch, exp_q[ch].size(), 0);
        idle(2);
    endtask

    task automatic wait_cyc(input longint target);
        do @(negedge clk); while (cyc < target);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int ch = 0; ch < 3; ch++) begin
            if (!rst) begin
                pv[ch] = 1'b0;
            end else begin
                if (ov[ch]) got_ovr[ch]++;
                if (mv[ch] && !pv[ch] && exp_q[ch].size() != 0)
                    chk("valid_latency", ch, cyc, exp_q[ch][0].due);
                if (mv[ch] && (m_ready[ch] || !pv[ch]) && exp_q[ch].size() == 0)
                    chk("unexpected_word", ch, 1, 0);
                if (mv[ch] && m_ready[ch] && exp_q[ch].size() != 0) begin
                    e = exp_q[ch].pop_front();
                    chk("m_data", ch, md_all[ch], e.data);
                    chk("parity_err", ch, pe[ch], e.perr);
                    chk("frame_err", ch, fe[ch], e.ferr);
                end
                pv[ch] = mv[ch];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        longint c0;
        rst = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            rx[ch]      = 1'b1;
            m_ready[ch] = 1'b1;
        end
        idle(4);
        rst = 1'b1;
        idle(3);
        @(negedge clk);
        chk("reset_m_valid", 0, mv[0], 0);
        chk("reset_m_data", 0, md0, 0);
        chk("reset_parity_err", 0, pe[0], 0);
        chk("reset_frame_err", 0, fe[0], 0);
        chk("reset_overrun", 0, ov[0], 0);
        chk("reset_busy", 0, bz[0], 0);
        idle(1);

        send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(20);

        // Start-bit glitch: 5 low cycles must be rejected at the half-bit check.
        c0 = cyc;
        rx[0] = 1'b0;
        idle(5);
        rx[0] = 1'b1;
        wait_cyc(c0 + 4);
        chk("glitch_busy_start", 0, bz[0], 1);
        wait_cyc(c0 + 10);
        chk("glitch_busy_mid", 0, bz[0], 1);
        wait_cyc(c0 + 11);
        chk("glitch_busy_idle", 0, bz[0], 0);
        idle(20);

        send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(10);

        // Second stop bit low, then line held low for 3 bit-times.
        send_frame(1, 8'h25, par_of(1, 8'h25), 1'b1, 1'b0, 1'b0);
        idle(3 * DIV[1]);
        @(negedge clk);
        chk("break_busy", 1, bz[1], 1);
        idle(1);
        rx[1] = 1'b1;
        idle(10);
        @(negedge clk);
        chk("break_released", 1, bz[1], 0);
        idle(1);
        send_frame(1, 8'h5A, par_of(1, 8'h5A), 1'b1, 1'b1, 1'b1);
        drain();

        // Overrun: consumer stalled, two back-to-back frames.
        m_ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b1);
        idle(10);
        @(negedge clk);
        chk("held_valid", 0, mv[0], 1);
        chk("held_data", 0, md0, 8'h11);
        idle(1);
        m_ready[0] = 1'b1;
        idle(2);
        @(negedge clk);
        chk("accepted_valid", 0, mv[0], 0);
        chk("overrun_count_mid", 0, got_ovr[0], 1);
        drain();

        // Reset in the middle of the data bits of 0x77.
        drive_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1);
        rx[0] = 1'b0;
        idle(DIV[0] / 2);
        rst = 1'b0;
        #2;
        chk("midreset_m_valid", 0, mv[0], 0);
        chk("midreset_m_data", 0, md0, 0);
        chk("midreset_flags", 0, {pe[0], fe[0], ov[0]}, 0);
        chk("midreset_busy", 0, bz[0], 0);
        rx[0] = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(5);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b1);
        drain();

        fork
            rand_ch(0, 12);
            rand_ch(1, 25);
            rand_ch(2, 16);
        join
        drain();
        idle(5);

        for (int ch = 0; ch < 3; ch++) chk("overrun_count", ch, got_ovr[ch], exp_ovr[ch]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
